// File: rtl/sawtooth_iter.sv
// Iterated fixed-point sawtooth chaos map: x <- frac(k*x), with an optional folded mode.
// A serial shift-add multiplier forms each product; iterates stream out over valid/ready.
module sawtooth_iter #(
  parameter int W  = 32,
  parameter int KI = 8,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [W-1:0]    x0,
  input  logic [KI+W-1:0] k,
  input  logic            mode,
  input  logic [CW-1:0]   iters,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic            out_last,
  output logic            done,
  output logic [1:0]      dbg_state
);

  localparam int AW = 2*W + KI;
  localparam int IW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_OUT = 2'd2, S_FIN = 2'd3} state_t;

  state_t          state_q;
  logic [AW-1:0]   acc_q, acc_d;
  logic [IW-1:0]   bit_q;
  logic [W-1:0]    x_q;
  logic [KI+W-1:0] k_q;
  logic            mode_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    iter_d;
  logic            busy_q, out_valid_q, out_last_q, done_q;
  logic [W-1:0]    out_data_q;

  // Handshake: an iterate transfers on a rising edge where out_valid and out_ready
  // are both high; out_data/out_last are held unchanged until that edge.

  // One shift-add step; on the last step acc_d is the full product P = k*x.
  logic [AW-1:0] k_ext;
  logic [W-1:0]  frac_part;
  always_comb begin
    k_ext     = {{W{1'b0}}, k_q};
    acc_d     = acc_q + (x_q[bit_q] ? (k_ext << bit_q) : '0);
    frac_part = acc_d[2*W-1:W];
    iter_d    = (mode_q && acc_d[2*W]) ? ~frac_part : frac_part;
    cnt_d     = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      bit_q       <= '0;
      x_q         <= '0;
      k_q         <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            x_q    <= x0;
            k_q    <= k;
            mode_q <= mode;
            cnt_q  <= iters;
            busy_q <= 1'b1;
            if (iters != '0) begin
              acc_q   <= '0;
              bit_q   <= '0;
              state_q <= S_MUL;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end
          end
        end
        S_MUL: begin
          acc_q <= acc_d;
          bit_q <= bit_q + IW'(1);
          if (bit_q == IW'(W-1)) begin
            // The emitted value is also the next seed, so folding shapes the trajectory.
            out_data_q  <= iter_d;
            x_q         <= iter_d;
            cnt_q       <= cnt_d;
            out_last_q  <= (cnt_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              acc_q   <= '0;
              bit_q   <= '0;
              state_q <= S_MUL;
            end
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sawtooth_iter.sv
// Directed bench for sawtooth_iter at W=16, KI=4, CW=16 with hand-computed iterates.
module tb_sawtooth_iter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] x0;
  logic [19:0] k;
  logic        mode;
  logic [15:0] iters;
  logic        busy, out_valid, out_ready, out_last, done;
  logic [15:0] out_data;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int t     = 0;
  logic ok;

  sawtooth_iter #(.W(16), .KI(4), .CW(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .x0(x0), .k(k), .mode(mode),
    .iters(iters), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk);
    t++;
  endtask

  // Presents a start for one edge (edge 0); t counts edges after it.
  task automatic launch(input logic [15:0] xs, input logic [19:0] ks, input logic m,
                        input logic [15:0] n);
    x0 = xs; k = ks; mode = m; iters = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
  endtask

  task automatic wait_valid(input int budget, output logic got);
    int n = 0;
    while (!out_valid && n < budget) begin
      step();
      n++;
    end
    got = out_valid;
  endtask

  // Two-iterate run with out_ready high; optionally injects a start mid-run.
  task automatic run_two(input string tag, input logic m, input logic [15:0] e1,
                         input logic [15:0] e2, input logic inject);
    launch(16'h4000, 20'h28000, m, 16'd2);
    if (inject) begin
      repeat (4) step();
      x0 = 16'h1234; k = 20'h10000; mode = ~m; iters = 16'd5; start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_busy_mid"}, busy, 1);
    end
    wait_valid(40, ok);
    chk({tag, "_to1"}, ok, 1);
    chk({tag, "_t1"}, t, 16);
    chk({tag, "_d1"}, out_data, e1);
    chk({tag, "_l1"}, out_last, 0);
    step();
    wait_valid(40, ok);
    chk({tag, "_to2"}, ok, 1);
    chk({tag, "_t2"}, t, 33);
    chk({tag, "_d2"}, out_data, e2);
    chk({tag, "_l2"}, out_last, 1);
    step();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_fin"}, busy, 1);
    chk({tag, "_valid_fin"}, out_valid, 0);
    // A start during FIN must be ignored.
    x0 = 16'h1111; k = 20'h30000; iters = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_done_end"}, done, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_state_end"}, dbg_state, 0);
    step();
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; x0 = '0; k = '0; mode = 1'b0; iters = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_two("saw", 1'b0, 16'hA000, 16'h9000, 1'b0);
    run_two("fold", 1'b1, 16'hA000, 16'h6FFF, 1'b0);

    // Backpressure: ready low for 5 cycles while the first iterate is valid.
    out_ready = 1'b0;
    launch(16'h4000, 20'h28000, 1'b0, 16'd2);
    wait_valid(40, ok);
    chk("bp_to1", ok, 1);
    chk("bp_t1", t, 16);
    repeat (5) begin
      step();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 16'hA000);
      chk("bp_hold_last", out_last, 0);
    end
    out_ready = 1'b1;
    step();
    wait_valid(40, ok);
    chk("bp_to2", ok, 1);
    chk("bp_t2", t, 38);
    chk("bp_d2", out_data, 16'h9000);
    chk("bp_l2", out_last, 1);
    step();
    chk("bp_done", done, 1);
    repeat (2) step();

    // Zero iterations: done the cycle after start, no output.
    launch(16'h4000, 20'h28000, 1'b0, 16'd0);
    chk("z_done", done, 1);
    chk("z_valid", out_valid, 0);
    chk("z_busy", busy, 1);
    step();
    chk("z_done_end", done, 0);
    chk("z_busy_end", busy, 0);
    chk("z_valid_end", out_valid, 0);
    step();

    // Zero gain yields zero iterates.
    launch(16'h4000, 20'h00000, 1'b0, 16'd1);
    wait_valid(40, ok);
    chk("k0_to", ok, 1);
    chk("k0_data", out_data, 0);
    chk("k0_last", out_last, 1);
    step();
    chk("k0_done", done, 1);
    repeat (2) step();

    run_two("mid", 1'b0, 16'hA000, 16'h9000, 1'b1);

    // Reset during the first multiply aborts the run.
    launch(16'h4000, 20'h28000, 1'b0, 16'd2);
    repeat (8) step();
    chk("ra_state_pre", dbg_state, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ra_busy", busy, 0);
    chk("ra_valid", out_valid, 0);
    chk("ra_data", out_data, 0);
    chk("ra_last", out_last, 0);
    chk("ra_state", dbg_state, 0);
    repeat (3) begin
      step();
      chk("ra_no_done", done, 0);
    end
    reset_n = 1'b1;
    step();
    chk("ra_idle_done", done, 0);
    run_two("post", 1'b0, 16'hA000, 16'h9000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
